// File: rtl/mmio_uart_counters_if.sv
// EX-stage MMIO access bus between the pipeline controller and the MMIO unit.
// The MMIO unit returns load data one cycle later, in the MEM/WB cycle.
interface mmio_uart_counters_if;
  logic [2:0]  ex_mmap_sel;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic        inst_retire;
  logic [31:0] mmio_rdata;

  modport master (
    output ex_mmap_sel,
    output ex_addr,
    output ex_wdata,
    output inst_retire,
    input  mmio_rdata
  );

  modport slave (
    input  ex_mmap_sel,
    input  ex_addr,
    input  ex_wdata,
    input  inst_retire,
    output mmio_rdata
  );
endinterface

// File: rtl/mmio_uart_counters.sv
// MMIO unit: UART RX/TX holding bytes plus cycle and retired-instruction counters,
// decoded from EX-stage accesses, with registered load data for writeback.
module mmio_uart_counters #(
  parameter logic [31:0] MMIO_BASE = 32'h8000_0000,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  mmio_uart_counters_if.slave    bus,
  input  logic [7:0]             uart_rx_data,
  input  logic                   uart_rx_valid,
  output logic                   uart_rx_ready,
  output logic [7:0]             uart_tx_data,
  output logic                   uart_tx_valid,
  input  logic                   uart_tx_ready
);

  localparam logic [2:0]       SEL_LOAD  = 3'd1;
  localparam logic [2:0]       SEL_STORE = 3'd2;
  localparam logic [31:0]      ADDR_CTRL = MMIO_BASE + 32'h0000_0000;
  localparam logic [31:0]      ADDR_RX   = MMIO_BASE + 32'h0000_0004;
  localparam logic [31:0]      ADDR_TX   = MMIO_BASE + 32'h0000_0008;
  localparam logic [31:0]      ADDR_CC   = MMIO_BASE + 32'h0000_0010;
  localparam logic [31:0]      ADDR_IC   = MMIO_BASE + 32'h0000_0014;
  localparam logic [31:0]      ADDR_RST  = MMIO_BASE + 32'h0000_0018;
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  function automatic logic [31:0] zext_cnt(input logic [CNT_W-1:0] v);
    zext_cnt           = 32'h0000_0000;
    zext_cnt[CNT_W-1:0] = v;
  endfunction

  logic             rx_full_r, tx_full_r;
  logic [7:0]       rx_byte_r, tx_byte_r;
  logic [CNT_W-1:0] cyc_cnt_r, inst_cnt_r;
  logic [31:0]      rdata_r;

  logic             rx_full_nxt_s, tx_full_nxt_s;
  logic [7:0]       rx_byte_nxt_s, tx_byte_nxt_s;
  logic [CNT_W-1:0] cyc_cnt_nxt_s, inst_cnt_nxt_s;
  logic [31:0]      rdata_nxt_s;

  logic is_load_s, is_store_s;
  logic rx_pop_s, rx_cap_s, tx_push_s, tx_done_s, cnt_clr_s;
  logic unused_wdata_s;

  assign is_load_s      = (bus.ex_mmap_sel == SEL_LOAD);
  assign is_store_s     = (bus.ex_mmap_sel == SEL_STORE);
  assign rx_pop_s       = is_load_s && (bus.ex_addr == ADDR_RX) && rx_full_r;
  assign rx_cap_s       = uart_rx_valid && !rx_full_r;
  // Handshake is evaluated against the pre-edge tx_full, so a colliding store is dropped.
  assign tx_done_s      = tx_full_r && uart_tx_ready;
  assign tx_push_s      = is_store_s && (bus.ex_addr == ADDR_TX) && !tx_full_r;
  assign cnt_clr_s      = is_store_s && (bus.ex_addr == ADDR_RST);
  assign unused_wdata_s = ^bus.ex_wdata[31:8];

  // Read mux: values sampled before this edge's updates; anything unreadable returns zero.
  always_comb begin
    rdata_nxt_s = 32'h0000_0000;
    if (!is_load_s) begin
      rdata_nxt_s = 32'h0000_0000;
    end else if (bus.ex_addr == ADDR_CTRL) begin
      rdata_nxt_s = {30'b0, rx_full_r, !tx_full_r};
    end else if (bus.ex_addr == ADDR_RX) begin
      rdata_nxt_s = {24'b0, rx_byte_r};
    end else if (bus.ex_addr == ADDR_CC) begin
      rdata_nxt_s = zext_cnt(cyc_cnt_r);
    end else if (bus.ex_addr == ADDR_IC) begin
      rdata_nxt_s = zext_cnt(inst_cnt_r);
    end else begin
      rdata_nxt_s = 32'h0000_0000;
    end
  end

  // Next-state for the holding buffers and counters.
  always_comb begin
    rx_full_nxt_s  = rx_full_r;
    rx_byte_nxt_s  = rx_byte_r;
    tx_full_nxt_s  = tx_full_r;
    tx_byte_nxt_s  = tx_byte_r;
    cyc_cnt_nxt_s  = cyc_cnt_r + CNT_ONE;
    inst_cnt_nxt_s = inst_cnt_r + (bus.inst_retire ? CNT_ONE : CNT_ZERO);

    if (rx_pop_s) begin
      rx_full_nxt_s = 1'b0;
    end else if (rx_cap_s) begin
      rx_full_nxt_s = 1'b1;
      rx_byte_nxt_s = uart_rx_data;
    end else begin
      rx_full_nxt_s = rx_full_r;
    end

    if (tx_done_s) begin
      tx_full_nxt_s = 1'b0;
    end else if (tx_push_s) begin
      tx_full_nxt_s = 1'b1;
      tx_byte_nxt_s = bus.ex_wdata[7:0];
    end else begin
      tx_full_nxt_s = tx_full_r;
    end

    if (cnt_clr_s) begin
      cyc_cnt_nxt_s  = CNT_ZERO;
      inst_cnt_nxt_s = CNT_ZERO;
    end else begin
      cyc_cnt_nxt_s  = cyc_cnt_r + CNT_ONE;
    end
  end

  // State and registered load data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_full_r  <= 1'b0;
      tx_full_r  <= 1'b0;
      rx_byte_r  <= 8'h00;
      tx_byte_r  <= 8'h00;
      cyc_cnt_r  <= CNT_ZERO;
      inst_cnt_r <= CNT_ZERO;
      rdata_r    <= 32'h0000_0000;
    end else begin
      rx_full_r  <= rx_full_nxt_s;
      tx_full_r  <= tx_full_nxt_s;
      rx_byte_r  <= rx_byte_nxt_s;
      tx_byte_r  <= tx_byte_nxt_s;
      cyc_cnt_r  <= cyc_cnt_nxt_s;
      inst_cnt_r <= inst_cnt_nxt_s;
      rdata_r    <= rdata_nxt_s;
    end
  end

  assign bus.mmio_rdata = rdata_r;
  assign uart_rx_ready  = !rx_full_r;
  assign uart_tx_valid  = tx_full_r;
  assign uart_tx_data   = tx_byte_r;

endmodule
